ysyx_22040383_id_ex_stage: RTL and testbench
============================================

Name: ysyx_22040383_id_ex_stage

Overview:
- ID→EX pipeline register of the five-stage core; consumes hazard-control outputs (forwarding_a/b_option, flush_exe_reg, stall_id_reg) and produces the EX-side state the hazard unit reads back (exe_rd, exe_has_rd, exe_instr_opcode, ex_is_flushed).
- Applies operand forwarding at capture time and keeps per-operand hold registers, so a producer retiring while ID is held cannot be lost.
- Implements the valid/ready handshake toward a possibly multi-cycle EX stage and keeps stall/bubble performance counters.

Parameters:
- XLEN, 64, datapath width.
- CNT_W, 32, performance counter width (saturating).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_ready  out  1  ID instruction accepted this cycle.
- id_pc  in  XLEN  ID pc.
- id_instr  in  32  ID instruction.
- id_rd  in  5  destination register.
- id_has_rd  in  1  instruction writes rd.
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data.
- id_imm  in  XLEN  decoded immediate.
- forwarding_a_option, forwarding_b_option  in  2 each  00 regfile, 01 EX, 10 MEM, 11 WB.
- exe_fwd_data, mem_fwd_data, wb_fwd_data  in  XLEN each  forwarding sources.
- flush_exe_reg  in  1  load-use: insert bubble.
- stall_id_reg  in  1  load-use: hold ID.
- redirect  in  1  branch/jump taken in EX: kill ID/EX contents.
- ex_ready  in  1  EX can accept a new instruction.
- ex_valid  out  1  EX holds a valid instruction.
- ex_is_flushed  out  1  EX slot is a bubble.
- ex_pc  out  XLEN; ex_instr  out  32; ex_imm  out  XLEN.
- exe_rd  out  5; exe_has_rd  out  1; exe_instr_opcode  out  7 (ex_instr[6:0]).
- ex_src_a, ex_src_b  out  XLEN  resolved operands.
- stall_cnt, bubble_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset: ex_valid=0, ex_is_flushed=1, every data/pc/instr output=0, exe_has_rd=0, hold valids=0, counters=0.
- id_ready = ex_ready & ~stall_id_reg & ~redirect (combinational).
- Operand select per side: option≠00 → selected forwarding source; else hold_valid → hold value; else regfile data.
- Register update priority at each posedge:
  1. rst.
  2. redirect: ex_valid=0, ex_is_flushed=1, exe_has_rd=0; both hold valids cleared.
  3. ~ex_ready: all EX outputs hold unchanged (flush_exe_reg ignored).
  4. flush_exe_reg: bubble (ex_valid=0, ex_is_flushed=1, exe_has_rd=0, ex_instr=0x00000013 NOP); bubble_cnt++.
  5. id_valid & id_ready: capture pc/instr/imm/rd/has_rd and resolved operands; ex_valid=1, ex_is_flushed=0; hold valids cleared.
  6. Otherwise: bubble as in step 4, but bubble_cnt is not incremented.
- Hold capture:
  - Condition: id_valid & ~id_ready & ~redirect.
  - For each side whose option≠00: hold ← forwarded value, hold_valid ← 1.
  - Newer forwarding overwrites older.
- stall_cnt increments in every cycle with id_valid & ~id_ready.
- Both counters saturate at all-ones. Counters are unaffected by redirect and cleared only by rst.
- Latency: 1 cycle from ID acceptance to ex_valid.
- Simultaneous events: redirect beats stall and flush; stall_id_reg with flush_exe_reg yields a bubble while ID holds.
- ex_ready low together with flush_exe_reg: hold wins; the hazard re-asserts next cycle.
- Reset mid-stall: hold registers are discarded.

Test Plan:
- Reset, then id_valid=1, id_pc=0x80000000, option 00, id_rs1_data=5 → next cycle ex_valid=1, ex_pc=0x80000000, ex_src_a=5, ex_is_flushed=0.
- forwarding_a_option=01, exe_fwd_data=0x1234, forwarding_b_option=11, wb_fwd_data=7 → ex_src_a=0x1234, ex_src_b=7.
- Load-use: stall_id_reg=1 and flush_exe_reg=1 for 1 cycle → id_ready=0; EX gets NOP with ex_is_flushed=1; bubble_cnt=1, stall_cnt=1; same ID instruction captured next cycle.
- ex_ready=0 for 3 cycles while option_b=10 with mem_fwd_data=9 in cycle 1, then 00 with regfile data=0 → EX outputs frozen; on release ex_src_b=9 (from hold); stall_cnt=3.
- redirect during stall with hold_valid=1 → ex_valid=0, hold cleared; the next accepted instruction uses regfile data.
- Drive stall for 2^CNT_W+2 cycles (CNT_W overridden to 4) → stall_cnt saturates at 15.

Source files
------------

// File: rtl/ysyx_22040383_id_ex_stage_if.sv
// ID->EX boundary bundle: ID-side instruction/operands, hazard controls,
// forwarding sources, and the EX-side state fed back to the hazard unit.
interface ysyx_22040383_id_ex_stage_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic             id_ready;
  logic [XLEN-1:0]  id_pc;
  logic [31:0]      id_instr;
  logic [4:0]       id_rd;
  logic             id_has_rd;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic [1:0]       forwarding_a_option;
  logic [1:0]       forwarding_b_option;
  logic [XLEN-1:0]  exe_fwd_data;
  logic [XLEN-1:0]  mem_fwd_data;
  logic [XLEN-1:0]  wb_fwd_data;
  logic             flush_exe_reg;
  logic             stall_id_reg;
  logic             redirect;
  logic             ex_ready;
  logic             ex_valid;
  logic             ex_is_flushed;
  logic [XLEN-1:0]  ex_pc;
  logic [31:0]      ex_instr;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       exe_rd;
  logic             exe_has_rd;
  logic [6:0]       exe_instr_opcode;
  logic [XLEN-1:0]  ex_src_a;
  logic [XLEN-1:0]  ex_src_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output id_valid, id_pc, id_instr, id_rd, id_has_rd, id_rs1_data, id_rs2_data, id_imm,
           forwarding_a_option, forwarding_b_option, exe_fwd_data, mem_fwd_data, wb_fwd_data,
           flush_exe_reg, stall_id_reg, redirect, ex_ready,
    input  id_ready, ex_valid, ex_is_flushed, ex_pc, ex_instr, ex_imm, exe_rd, exe_has_rd,
           exe_instr_opcode, ex_src_a, ex_src_b, stall_cnt, bubble_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_instr, id_rd, id_has_rd, id_rs1_data, id_rs2_data, id_imm,
           forwarding_a_option, forwarding_b_option, exe_fwd_data, mem_fwd_data, wb_fwd_data,
           flush_exe_reg, stall_id_reg, redirect, ex_ready,
    output id_ready, ex_valid, ex_is_flushed, ex_pc, ex_instr, ex_imm, exe_rd, exe_has_rd,
           exe_instr_opcode, ex_src_a, ex_src_b, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/ysyx_22040383_id_ex_stage.sv
// ID->EX pipeline register: operand forwarding at capture, per-operand hold
// registers across ID stalls, valid/ready toward EX, stall/bubble counters.
module ysyx_22040383_id_ex_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input logic                        clk,
  input logic                        rst,
  ysyx_22040383_id_ex_stage_if.slave bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    UPD_REDIRECT,
    UPD_FREEZE,
    UPD_FLUSH,
    UPD_ACCEPT,
    UPD_IDLE
  } upd_e;

  upd_e             upd;
  logic             id_ready_c;
  logic             stall_c;
  logic [XLEN-1:0]  src_a;
  logic [XLEN-1:0]  src_b;
  logic [XLEN-1:0]  hold_a;
  logic [XLEN-1:0]  hold_b;
  logic             hold_a_valid;
  logic             hold_b_valid;

  logic             ex_valid_q;
  logic             ex_is_flushed_q;
  logic [XLEN-1:0]  ex_pc_q;
  logic [31:0]      ex_instr_q;
  logic [XLEN-1:0]  ex_imm_q;
  logic [4:0]       exe_rd_q;
  logic             exe_has_rd_q;
  logic [XLEN-1:0]  ex_src_a_q;
  logic [XLEN-1:0]  ex_src_b_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // A live forward always beats a held value; the hold only covers a producer
  // that already retired while ID was stalled.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [1:0]      opt,
    input logic            hv,
    input logic [XLEN-1:0] hd,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] ex,
    input logic [XLEN-1:0] mem,
    input logic [XLEN-1:0] wb
  );
    case (opt)
      2'b01:   return ex;
      2'b10:   return mem;
      2'b11:   return wb;
      default: return hv ? hd : rf;
    endcase
  endfunction

  always_comb begin
    id_ready_c = bus.ex_ready & ~bus.stall_id_reg & ~bus.redirect;
    stall_c    = bus.id_valid & ~id_ready_c;
    src_a = pick_operand(bus.forwarding_a_option, hold_a_valid, hold_a, bus.id_rs1_data,
                         bus.exe_fwd_data, bus.mem_fwd_data, bus.wb_fwd_data);
    src_b = pick_operand(bus.forwarding_b_option, hold_b_valid, hold_b, bus.id_rs2_data,
                         bus.exe_fwd_data, bus.mem_fwd_data, bus.wb_fwd_data);
    upd = UPD_IDLE;
    if (bus.redirect)                       upd = UPD_REDIRECT;
    else if (!bus.ex_ready)                 upd = UPD_FREEZE;
    else if (bus.flush_exe_reg)             upd = UPD_FLUSH;
    else if (bus.id_valid && id_ready_c)    upd = UPD_ACCEPT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_is_flushed_q <= 1'b1;
      ex_pc_q         <= '0;
      ex_instr_q      <= '0;
      ex_imm_q        <= '0;
      exe_rd_q        <= '0;
      exe_has_rd_q    <= 1'b0;
      ex_src_a_q      <= '0;
      ex_src_b_q      <= '0;
      hold_a          <= '0;
      hold_b          <= '0;
      hold_a_valid    <= 1'b0;
      hold_b_valid    <= 1'b0;
      stall_cnt_q     <= '0;
      bubble_cnt_q    <= '0;
    end else begin
      if (stall_c && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (upd == UPD_FLUSH && bubble_cnt_q != '1)
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);

      case (upd)
        UPD_REDIRECT: begin
          ex_valid_q      <= 1'b0;
          ex_is_flushed_q <= 1'b1;
          exe_has_rd_q    <= 1'b0;
        end
        UPD_FREEZE: begin
        end
        UPD_ACCEPT: begin
          ex_valid_q      <= 1'b1;
          ex_is_flushed_q <= 1'b0;
          ex_pc_q         <= bus.id_pc;
          ex_instr_q      <= bus.id_instr;
          ex_imm_q        <= bus.id_imm;
          exe_rd_q        <= bus.id_rd;
          exe_has_rd_q    <= bus.id_has_rd;
          ex_src_a_q      <= src_a;
          ex_src_b_q      <= src_b;
        end
        default: begin
          ex_valid_q      <= 1'b0;
          ex_is_flushed_q <= 1'b1;
          exe_has_rd_q    <= 1'b0;
          ex_instr_q      <= NOP;
        end
      endcase

      if (upd == UPD_REDIRECT) begin
        hold_a_valid <= 1'b0;
        hold_b_valid <= 1'b0;
      end else if (stall_c) begin
        if (bus.forwarding_a_option != 2'b00) begin
          hold_a       <= src_a;
          hold_a_valid <= 1'b1;
        end
        if (bus.forwarding_b_option != 2'b00) begin
          hold_b       <= src_b;
          hold_b_valid <= 1'b1;
        end
      end else if (upd == UPD_ACCEPT) begin
        hold_a_valid <= 1'b0;
        hold_b_valid <= 1'b0;
      end
    end
  end

  assign bus.id_ready         = id_ready_c;
  assign bus.ex_valid         = ex_valid_q;
  assign bus.ex_is_flushed    = ex_is_flushed_q;
  assign bus.ex_pc            = ex_pc_q;
  assign bus.ex_instr         = ex_instr_q;
  assign bus.ex_imm           = ex_imm_q;
  assign bus.exe_rd           = exe_rd_q;
  assign bus.exe_has_rd       = exe_has_rd_q;
  assign bus.exe_instr_opcode = ex_instr_q[6:0];
  assign bus.ex_src_a         = ex_src_a_q;
  assign bus.ex_src_b         = ex_src_b_q;
  assign bus.stall_cnt        = stall_cnt_q;
  assign bus.bubble_cnt       = bubble_cnt_q;
endmodule

// File: tb/tb_ysyx_22040383_id_ex_stage.sv
// Bench for the ID->EX register: directed vector table, randomized run against
// a behavioural model, and a counter saturation sequence.
module tb_ysyx_22040383_id_ex_stage;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] P0 = 64'h8000_0000, P1 = 64'h8000_0004, P2 = 64'h8000_0008,
                          P3 = 64'h8000_000c, P4 = 64'h8000_0010;
  localparam logic [31:0] I1 = 32'h0050_0093, I2 = 32'h0020_8133, I3 = 32'h0031_01b3,
                          I4 = 32'h0041_8233, I5 = 32'h0052_02b3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22040383_id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  ysyx_22040383_id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, v; logic [63:0] pc; logic [31:0] ins; logic [63:0] rs1, rs2;
    logic [1:0] fa, fb; logic [63:0] fx, fm, fw; logic fl, st, rd, er;
    logic e_rdy, e_v, e_fl; logic [63:0] e_pc, e_a, e_b; logic [31:0] e_ins; int e_sc, e_bc;
  } vec_t;
  vec_t tbl[14];

  // Behavioural model of the EX-side state
  logic m_valid, m_fl, m_hasrd;
  logic [63:0] m_pc, m_imm, m_a, m_b;
  logic [31:0] m_ins;
  logic [4:0]  m_rd;
  bit          hv[2];
  logic [63:0] hd[2];
  int          m_sc, m_bc;

  function automatic bit model_ready();
    return bus.ex_ready && !bus.stall_id_reg && !bus.redirect;
  endfunction

  function automatic logic [63:0] resolve(input logic [1:0] opt, input int side, input logic [63:0] rf);
    if (opt == 2'd1) return bus.exe_fwd_data;
    if (opt == 2'd2) return bus.mem_fwd_data;
    if (opt == 2'd3) return bus.wb_fwd_data;
    return hv[side] ? hd[side] : rf;
  endfunction

  task automatic model_bubble();
    m_valid = 1'b0; m_fl = 1'b1; m_hasrd = 1'b0; m_ins = NOP;
  endtask

  task automatic model_step();
    logic [63:0] ra, rb;
    bit rdy, stalled;
    if (rst) begin
      m_valid = 0; m_fl = 1; m_hasrd = 0; m_pc = 0; m_imm = 0; m_a = 0; m_b = 0;
      m_ins = 0; m_rd = 0; hv[0] = 0; hv[1] = 0; m_sc = 0; m_bc = 0;
      return;
    end
    rdy = model_ready();
    stalled = bus.id_valid && !rdy;
    ra = resolve(bus.forwarding_a_option, 0, bus.id_rs1_data);
    rb = resolve(bus.forwarding_b_option, 1, bus.id_rs2_data);
    if (stalled && m_sc < CMAX) m_sc++;
    if (bus.redirect) begin
      m_valid = 0; m_fl = 1; m_hasrd = 0; hv[0] = 0; hv[1] = 0;
      return;
    end
    if (bus.ex_ready) begin
      if (bus.flush_exe_reg) begin
        model_bubble();
        if (m_bc < CMAX) m_bc++;
      end else if (bus.id_valid && rdy) begin
        m_valid = 1; m_fl = 0; m_pc = bus.id_pc; m_ins = bus.id_instr; m_imm = bus.id_imm;
        m_rd = bus.id_rd; m_hasrd = bus.id_has_rd; m_a = ra; m_b = rb;
        hv[0] = 0; hv[1] = 0;
      end else begin
        model_bubble();
      end
    end
    if (stalled) begin
      if (bus.forwarding_a_option != 0) begin hv[0] = 1; hd[0] = ra; end
      if (bus.forwarding_b_option != 0) begin hv[1] = 1; hd[1] = rb; end
    end
  endtask

  task automatic compare_model();
    chk("ex_valid", 64'(bus.ex_valid), 64'(m_valid));
    chk("ex_is_flushed", 64'(bus.ex_is_flushed), 64'(m_fl));
    chk("ex_pc", bus.ex_pc, m_pc);
    chk("ex_instr", 64'(bus.ex_instr), 64'(m_ins));
    chk("ex_imm", bus.ex_imm, m_imm);
    chk("exe_rd", 64'(bus.exe_rd), 64'(m_rd));
    chk("exe_has_rd", 64'(bus.exe_has_rd), 64'(m_hasrd));
    chk("exe_instr_opcode", 64'(bus.exe_instr_opcode), 64'(m_ins[6:0]));
    chk("ex_src_a", bus.ex_src_a, m_a);
    chk("ex_src_b", bus.ex_src_b, m_b);
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_sc));
    chk("bubble_cnt", 64'(bus.bubble_cnt), 64'(m_bc));
  endtask

  task automatic rand_inputs(input bit force_rst);
    rst = force_rst || ($urandom_range(99) == 0);
    bus.id_valid     = ($urandom_range(3) != 0);
    bus.id_pc        = {$urandom, $urandom};
    bus.id_instr     = $urandom;
    bus.id_rd        = 5'($urandom);
    bus.id_has_rd    = 1'($urandom);
    bus.id_rs1_data  = {$urandom, $urandom};
    bus.id_rs2_data  = {$urandom, $urandom};
    bus.id_imm       = {$urandom, $urandom};
    bus.forwarding_a_option = $urandom_range(1) ? 2'd0 : 2'($urandom_range(3));
    bus.forwarding_b_option = $urandom_range(1) ? 2'd0 : 2'($urandom_range(3));
    bus.exe_fwd_data = {$urandom, $urandom};
    bus.mem_fwd_data = {$urandom, $urandom};
    bus.wb_fwd_data  = {$urandom, $urandom};
    bus.stall_id_reg = ($urandom_range(4) == 0);
    bus.flush_exe_reg = bus.stall_id_reg ? 1'($urandom_range(1)) : ($urandom_range(9) == 0);
    bus.redirect     = ($urandom_range(9) == 0);
    bus.ex_ready     = ($urandom_range(3) != 0);
  endtask

  initial begin
    tbl[0]  = '{1,0,0, 0, 0,0,0,0,0,0,0,0,0,0,1, 1,0,1,0, 0, 0,0,  0,0};
    tbl[1]  = '{0,1,P0,I1,5,6,0,0,0,0,0,0,0,0,1, 1,1,0,P0,5, 6,I1, 0,0};
    tbl[2]  = '{0,1,P1,I2,5,6,1,3,'h1234,0,7,0,0,0,1, 1,1,0,P1,'h1234,7,I2,0,0};
    tbl[3]  = '{0,1,P2,I3,1,2,0,0,0,0,0,1,1,0,1, 0,0,1,P1,'h1234,7,NOP,1,1};
    tbl[4]  = '{0,1,P2,I3,1,2,0,0,0,0,0,0,0,0,1, 1,1,0,P2,1, 2,I3, 1,1};
    tbl[5]  = '{0,1,P3,I4,3,0,0,2,0,9,0,0,0,0,0, 0,1,0,P2,1, 2,I3, 2,1};
    tbl[6]  = '{0,1,P3,I4,3,0,0,0,0,0,0,0,0,0,0, 0,1,0,P2,1, 2,I3, 3,1};
    tbl[7]  = '{0,1,P3,I4,3,0,0,0,0,0,0,0,0,0,0, 0,1,0,P2,1, 2,I3, 4,1};
    tbl[8]  = '{0,1,P3,I4,3,0,0,0,0,0,0,0,0,0,1, 1,1,0,P3,3, 9,I4, 4,1};
    tbl[9]  = '{0,1,P4,I5,4,8,2,0,0,'h55,0,0,1,0,1, 0,0,1,P3,3,9,NOP,5,1};
    tbl[10] = '{0,1,P4,I5,4,8,0,0,0,0,0,0,1,1,1, 0,0,1,P3,3, 9,NOP,6,1};
    tbl[11] = '{0,1,P4,I5,4,8,0,0,0,0,0,0,0,0,1, 1,1,0,P4,4, 8,I5, 6,1};
    tbl[12] = '{0,0,0, 0, 0,0,0,0,0,0,0,0,0,0,1, 1,0,1,P4,4, 8,NOP,6,1};
    tbl[13] = '{0,0,0, 0, 0,0,0,0,0,0,0,1,0,0,1, 1,0,1,P4,4, 8,NOP,6,2};

    bus.id_imm = 64'h10; bus.id_rd = 5'd5; bus.id_has_rd = 1'b1;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; bus.id_valid = tbl[i].v; bus.id_pc = tbl[i].pc; bus.id_instr = tbl[i].ins;
      bus.id_rs1_data = tbl[i].rs1; bus.id_rs2_data = tbl[i].rs2;
      bus.forwarding_a_option = tbl[i].fa; bus.forwarding_b_option = tbl[i].fb;
      bus.exe_fwd_data = tbl[i].fx; bus.mem_fwd_data = tbl[i].fm; bus.wb_fwd_data = tbl[i].fw;
      bus.flush_exe_reg = tbl[i].fl; bus.stall_id_reg = tbl[i].st;
      bus.redirect = tbl[i].rd; bus.ex_ready = tbl[i].er;
      #1;
      chk($sformatf("tbl%0d_id_ready", i), 64'(bus.id_ready), 64'(tbl[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_ex_valid", i), 64'(bus.ex_valid), 64'(tbl[i].e_v));
      chk($sformatf("tbl%0d_ex_is_flushed", i), 64'(bus.ex_is_flushed), 64'(tbl[i].e_fl));
      chk($sformatf("tbl%0d_exe_has_rd", i), 64'(bus.exe_has_rd), 64'(tbl[i].e_v));
      chk($sformatf("tbl%0d_ex_pc", i), bus.ex_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_ex_src_a", i), bus.ex_src_a, tbl[i].e_a);
      chk($sformatf("tbl%0d_ex_src_b", i), bus.ex_src_b, tbl[i].e_b);
      chk($sformatf("tbl%0d_ex_instr", i), 64'(bus.ex_instr), 64'(tbl[i].e_ins));
      chk($sformatf("tbl%0d_stall_cnt", i), 64'(bus.stall_cnt), 64'(tbl[i].e_sc));
      chk($sformatf("tbl%0d_bubble_cnt", i), 64'(bus.bubble_cnt), 64'(tbl[i].e_bc));
    end

    for (int unsigned c = 0; c < 3000; c++) begin
      rand_inputs(c == 0);
      #1;
      chk("rnd_id_ready", 64'(bus.id_ready), 64'(model_ready()));
      @(posedge clk); #1;
      model_step();
      compare_model();
    end

    rst = 1'b1; bus.redirect = 1'b0; bus.ex_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.id_valid = 1'b1; bus.stall_id_reg = 1'b1; bus.flush_exe_reg = 1'b1;
    for (int i = 1; i <= CMAX + 3; i++) begin
      @(posedge clk); #1;
      chk("sat_stall_cnt", 64'(bus.stall_cnt), 64'((i < CMAX) ? i : CMAX));
      chk("sat_bubble_cnt", 64'(bus.bubble_cnt), 64'((i < CMAX) ? i : CMAX));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
